// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// mem_port_arbiter_pkg: arbiter state/owner encodings and the latched request record.
// Rev 1.0
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_MA = 1'b1
   } arb_owner_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mem_req_t;

   localparam logic [3:0] IF_BE = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_arb_pick.sv
`default_nettype none
// mem_port_arbiter_arb_pick: MA-priority picker that yields to IF once IF has lost STARVE_LIMIT times.
// Rev 1.0
module mem_port_arbiter_arb_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 3,
   parameter int STARVE_W     = 2
) (
   input  logic                if_valid,
   input  logic                ma_valid,
   input  logic [STARVE_W-1:0] starve_cnt,
   output logic                grant,
   output arb_owner_t          owner
);

   logic if_starved;

   assign if_starved = if_valid && (starve_cnt == STARVE_W'(STARVE_LIMIT));

   always_comb begin
      grant = if_valid || ma_valid;
      owner = (ma_valid && !if_starved) ? OWNER_MA : OWNER_IF;
   end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one memory port between IF and MA, one transaction outstanding at a time.
// Rev 1.0
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT     = 15,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_valid,
   input  logic [31:0] if_req_addr,
   output logic        if_resp_valid,
   output logic [31:0] if_resp_data,
   input  logic        ma_req_valid,
   input  logic        ma_req_we,
   input  logic [31:0] ma_req_addr,
   input  logic [31:0] ma_req_wdata,
   input  logic [3:0]  ma_req_be,
   output logic        ma_resp_valid,
   output logic [31:0] ma_resp_data,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   output logic [3:0]  mem_req_be,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        if_stall,
   output logic        ma_stall,
   output logic        timeout_error
);

   localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   arb_state_t            state, state_nxt;
   arb_owner_t            owner, owner_nxt;
   mem_req_t              req, req_nxt;
   logic [WAIT_W-1:0]     wait_cnt, wait_cnt_nxt;
   logic [STARVE_W-1:0]   starve_cnt, starve_cnt_nxt;
   logic [31:0]           resp_data, resp_data_nxt;
   logic                  timeout_flag, timeout_nxt;
   logic                  grant;
   arb_owner_t            pick_owner;
   logic                  issuing;
   logic                  responding;

   mem_port_arbiter_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .STARVE_W     (STARVE_W)
   ) u_pick (
      .if_valid   (if_req_valid),
      .ma_valid   (ma_req_valid),
      .starve_cnt (starve_cnt),
      .grant      (grant),
      .owner      (pick_owner)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         owner        <= OWNER_IF;
         req          <= '0;
         wait_cnt     <= '0;
         starve_cnt   <= '0;
         resp_data    <= '0;
         timeout_flag <= 1'b0;
      end else begin
         state        <= state_nxt;
         owner        <= owner_nxt;
         req          <= req_nxt;
         wait_cnt     <= wait_cnt_nxt;
         starve_cnt   <= starve_cnt_nxt;
         resp_data    <= resp_data_nxt;
         timeout_flag <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      req_nxt        = req;
      wait_cnt_nxt   = wait_cnt;
      starve_cnt_nxt = starve_cnt;
      resp_data_nxt  = resp_data;
      timeout_nxt    = timeout_flag;
      case (state)
         IDLE: begin
            if (grant) begin
               owner_nxt    = pick_owner;
               state_nxt    = ISSUE;
               wait_cnt_nxt = '0;
               if (pick_owner == OWNER_MA) begin
                  req_nxt.we    = ma_req_we;
                  req_nxt.addr  = ma_req_addr;
                  req_nxt.wdata = ma_req_wdata;
                  req_nxt.be    = ma_req_be;
                  if (if_req_valid && (starve_cnt != STARVE_MAX))
                     starve_cnt_nxt = starve_cnt + STARVE_W'(1);
               end else begin
                  req_nxt.we     = 1'b0;
                  req_nxt.addr   = if_req_addr;
                  req_nxt.wdata  = '0;
                  req_nxt.be     = IF_BE;
                  starve_cnt_nxt = '0;
               end
            end
         end
         ISSUE: begin
            if (mem_req_ready) begin
               state_nxt    = WAIT;
               wait_cnt_nxt = '0;
            end
         end
         WAIT: begin
            // A response in the final wait cycle beats the timeout.
            if (mem_resp_valid) begin
               resp_data_nxt = req.we ? 32'd0 : mem_resp_data;
               state_nxt     = RESP;
            end else if (wait_cnt == WAIT_LAST) begin
               resp_data_nxt = '0;
               timeout_nxt   = 1'b1;
               state_nxt     = RESP;
            end else begin
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign issuing    = (state == ISSUE);
   assign responding = (state == RESP);

   assign mem_req_valid = issuing;
   assign mem_req_we    = issuing && req.we;
   assign mem_req_addr  = issuing ? req.addr  : 32'd0;
   assign mem_req_wdata = issuing ? req.wdata : 32'd0;
   assign mem_req_be    = issuing ? req.be    : 4'd0;

   assign if_resp_valid = responding && (owner == OWNER_IF);
   assign ma_resp_valid = responding && (owner == OWNER_MA);
   assign if_resp_data  = if_resp_valid ? resp_data : 32'd0;
   assign ma_resp_data  = ma_resp_valid ? resp_data : 32'd0;

   // Stalls see only requester inputs and the registered response pulse.
   assign if_stall = if_req_valid && !if_resp_valid;
   assign ma_stall = ma_req_valid && !ma_resp_valid;

   assign timeout_error = timeout_flag;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: randomized requesters and memory, transaction-level model, queue scoreboard.
// Rev 1.0
module tb_mem_port_arbiter;

   localparam int MAX_WAIT     = 15;
   localparam int STARVE_LIMIT = 3;
   localparam int PH_FREE = 0, PH_ISS = 1, PH_WT = 2, PH_RSP = 3;

   logic        clk;
   logic        rst;
   logic        if_req_valid;
   logic [31:0] if_req_addr;
   logic        if_resp_valid;
   logic [31:0] if_resp_data;
   logic        ma_req_valid;
   logic        ma_req_we;
   logic [31:0] ma_req_addr;
   logic [31:0] ma_req_wdata;
   logic [3:0]  ma_req_be;
   logic        ma_resp_valid;
   logic [31:0] ma_resp_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_be;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        if_stall;
   logic        ma_stall;
   logic        timeout_error;

   mem_port_arbiter #(
      .MAX_WAIT     (MAX_WAIT),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .if_req_valid   (if_req_valid),
      .if_req_addr    (if_req_addr),
      .if_resp_valid  (if_resp_valid),
      .if_resp_data   (if_resp_data),
      .ma_req_valid   (ma_req_valid),
      .ma_req_we      (ma_req_we),
      .ma_req_addr    (ma_req_addr),
      .ma_req_wdata   (ma_req_wdata),
      .ma_req_be      (ma_req_be),
      .ma_resp_valid  (ma_resp_valid),
      .ma_resp_data   (ma_resp_data),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_we     (mem_req_we),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_be     (mem_req_be),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .if_stall       (if_stall),
      .ma_stall       (ma_stall),
      .timeout_error  (timeout_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        owner_ma;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          cyc;
   } exp_req_t;

   typedef struct {
      logic        owner_ma;
      logic [31:0] data;
      logic        tmo;
      int          cyc;
   } exp_resp_t;

   exp_req_t  req_q[$];
   exp_resp_t resp_q[$];
   exp_req_t  cur_req;
   exp_resp_t mon_r;
   logic      prev_mrv = 1'b0;

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   // Stimulus knobs (percent) and model state.
   int   if_pct, ma_pct, rdy_pct, tmo_pct;
   int   m_phase = PH_FREE;
   int   m_wcnt  = 0;
   int   m_lat   = 0;
   int   starve  = 0;
   logic m_tmo_mode = 1'b0;
   logic m_owner_ma = 1'b0;
   logic m_we       = 1'b0;
   logic m_tmo_flag = 1'b0;
   int   n_tmo = 0;
   int   n_forced_if = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctrl"}, {if_resp_valid, ma_resp_valid, mem_req_valid, mem_req_we,
                              if_stall, ma_stall, timeout_error, mem_req_be}, 64'd0);
      check({tag, "_resp_data"}, {if_resp_data, ma_resp_data}, 64'd0);
      check({tag, "_mem_fields"}, {mem_req_addr, mem_req_wdata}, 64'd0);
   endtask

   function automatic logic pct(input int p);
      return int'($urandom_range(0, 99)) < p;
   endfunction

   // Monitor: pops expected issues/responses whenever the DUT presents them.
   always @(negedge clk) begin
      if (mem_req_valid) begin
         if (!prev_mrv) begin
            if (req_q.size() == 0) begin
               check("unexpected_issue", 1, 0);
            end else begin
               cur_req = req_q.pop_front();
               check("issue_cycle", cycle, cur_req.cyc);
               check("issue_we",    mem_req_we,   cur_req.we);
               check("issue_addr",  mem_req_addr, cur_req.addr);
               check("issue_be",    mem_req_be,   cur_req.be);
               if (cur_req.owner_ma) check("issue_wdata", mem_req_wdata, cur_req.wdata);
            end
         end else begin
            check("issue_held", {mem_req_we, mem_req_addr, mem_req_be},
                  {cur_req.we, cur_req.addr, cur_req.be});
         end
      end
      prev_mrv = mem_req_valid;
      if (if_resp_valid || ma_resp_valid) begin
         if (resp_q.size() == 0) begin
            check("unexpected_resp", {if_resp_valid, ma_resp_valid}, 0);
         end else begin
            mon_r = resp_q.pop_front();
            check("resp_cycle", cycle, mon_r.cyc);
            check("resp_owner", {if_resp_valid, ma_resp_valid}, mon_r.owner_ma ? 2'b01 : 2'b10);
            check("resp_data", mon_r.owner_ma ? ma_resp_data : if_resp_data, mon_r.data);
            check("timeout_error", timeout_error, mon_r.tmo);
         end
      end
      check("if_stall", if_stall, if_req_valid && !if_resp_valid);
      check("ma_stall", ma_stall, ma_req_valid && !ma_resp_valid);
   end

   // One clock of requesters, memory and the transaction model.
   task automatic step();
      exp_req_t  er;
      exp_resp_t rr;
      logic      ma_wins;
      @(posedge clk);
      #1;
      cycle++;
      rst = 1'b0;
      if (if_resp_valid) if_req_valid = 1'b0;
      if (ma_resp_valid) ma_req_valid = 1'b0;
      if (!if_req_valid && pct(if_pct)) begin
         if_req_valid = 1'b1;
         if_req_addr  = $urandom & 32'hFFFF_FFFC;
      end
      if (!ma_req_valid && pct(ma_pct)) begin
         ma_req_valid = 1'b1;
         ma_req_we    = pct(50);
         ma_req_addr  = $urandom & 32'hFFFF_FFFC;
         ma_req_wdata = $urandom;
         ma_req_be    = 4'($urandom_range(0, 15));
      end
      mem_req_ready  = pct(rdy_pct);
      mem_resp_data  = $urandom;
      mem_resp_valid = (m_phase != PH_WT) ? pct(12) : 1'b0;
      case (m_phase)
         PH_FREE: begin
            if (if_req_valid || ma_req_valid) begin
               ma_wins = ma_req_valid && !(if_req_valid && starve == STARVE_LIMIT);
               if (ma_wins) begin
                  if (if_req_valid && starve < STARVE_LIMIT) starve++;
                  er = '{owner_ma: 1'b1, we: ma_req_we, addr: ma_req_addr,
                         wdata: ma_req_wdata, be: ma_req_be, cyc: cycle + 1};
               end else begin
                  if (ma_req_valid) n_forced_if++;
                  starve = 0;
                  er = '{owner_ma: 1'b0, we: 1'b0, addr: if_req_addr,
                         wdata: 32'd0, be: 4'hF, cyc: cycle + 1};
               end
               req_q.push_back(er);
               m_owner_ma = ma_wins;
               m_we       = ma_wins && ma_req_we;
               m_phase    = PH_ISS;
            end
         end
         PH_ISS: begin
            if (mem_req_ready) begin
               m_phase    = PH_WT;
               m_wcnt     = 0;
               m_tmo_mode = pct(tmo_pct);
               m_lat      = ($urandom_range(0, 7) == 0) ? MAX_WAIT - 1 : int'($urandom_range(0, 3));
            end
         end
         PH_WT: begin
            if (!m_tmo_mode && m_wcnt == m_lat) begin
               mem_resp_valid = 1'b1;
               rr = '{owner_ma: m_owner_ma, data: m_we ? 32'd0 : mem_resp_data,
                      tmo: m_tmo_flag, cyc: cycle + 1};
               resp_q.push_back(rr);
               m_phase = PH_RSP;
            end else if (m_wcnt == MAX_WAIT - 1) begin
               m_tmo_flag = 1'b1;
               n_tmo++;
               rr = '{owner_ma: m_owner_ma, data: 32'd0, tmo: 1'b1, cyc: cycle + 1};
               resp_q.push_back(rr);
               m_phase = PH_RSP;
            end else begin
               m_wcnt++;
            end
         end
         default: m_phase = PH_FREE;
      endcase
   endtask

   initial begin
      bit reached;
      rst            = 1'b1;
      if_req_valid   = 1'b0;
      if_req_addr    = 32'd0;
      ma_req_valid   = 1'b0;
      ma_req_we      = 1'b0;
      ma_req_addr    = 32'd0;
      ma_req_wdata   = 32'd0;
      ma_req_be      = 4'd0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");

      // Mixed traffic, starvation pressure, backpressure, timeouts.
      for (int ph = 0; ph < 4; ph++) begin
         case (ph)
            0: begin if_pct = 50;  ma_pct = 50;  rdy_pct = 70;  tmo_pct = 5;  end
            1: begin if_pct = 100; ma_pct = 100; rdy_pct = 100; tmo_pct = 0;  end
            2: begin if_pct = 40;  ma_pct = 40;  rdy_pct = 20;  tmo_pct = 5;  end
            default: begin if_pct = 50; ma_pct = 50; rdy_pct = 80; tmo_pct = 40; end
         endcase
         for (int k = 0; k < 600; k++) step();
      end

      // Reset while waiting on a response that never comes, then a late response.
      if_pct = 100; ma_pct = 0; rdy_pct = 100; tmo_pct = 100;
      reached = 1'b0;
      for (int k = 0; k < 300 && !reached; k++) begin
         step();
         reached = (m_phase == PH_WT) && m_tmo_mode && (m_wcnt >= 3);
      end
      check("reached_wait", reached, 1'b1);
      rst            = 1'b1;
      if_req_valid   = 1'b0;
      ma_req_valid   = 1'b0;
      mem_resp_valid = 1'b0;
      m_phase        = PH_FREE;
      starve         = 0;
      m_tmo_flag     = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         cycle++;
         rst            = 1'b0;
         mem_resp_valid = (k < 2);
         mem_resp_data  = 32'hA5A5_0000 | k;
         @(negedge clk);
         check_zero("post_reset");
      end

      check("resp_queue_empty", resp_q.size(), 0);
      check("issue_queue_empty", req_q.size(), 0);
      $display("info: timeouts=%0d forced_if_wins=%0d", n_tmo, n_forced_if);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
